// File: rtl/jtag_ir_dr_path_if.sv
// Signal bundle between the TAP controller side and the IR/DR data path.
// The controller strobes and serial input flow toward the data path. The
// TDO mux, the active instruction and the decoded selects flow back out.
interface jtag_ir_dr_path_if #(
    parameter int IR_W = 4
);
    logic            TDI;
    logic            clockir;
    logic            shiftir;
    logic            updateir;
    logic            clockdr;
    logic            shiftdr;
    logic            updatedr;
    logic            select;
    logic            bsr_tdo;
    logic            TDO;
    logic            tdo_en;
    logic [IR_W-1:0] instr;
    logic            sel_bypass;
    logic            sel_idcode;
    logic            sel_bsr;
    logic            bsr_mode;

    modport master (
        output TDI, clockir, shiftir, updateir, clockdr, shiftdr, updatedr,
               select, bsr_tdo,
        input  TDO, tdo_en, instr, sel_bypass, sel_idcode, sel_bsr, bsr_mode
    );

    modport slave (
        input  TDI, clockir, shiftir, updateir, clockdr, shiftdr, updatedr,
               select, bsr_tdo,
        output TDO, tdo_en, instr, sel_bypass, sel_idcode, sel_bsr, bsr_mode
    );
endinterface

// File: rtl/jtag_ir_dr_path.sv
// JTAG instruction register, instruction decoder, BYPASS and IDCODE data
// registers, and the TDO output mux. Runs entirely on TCK with a
// synchronous active-high TRST.
// Optional build macro IDCODE_EN: when defined, the 32-bit IDCODE register
// exists, OP_IDCODE selects it and it is the instruction after reset. When
// undefined, OP_IDCODE falls through to BYPASS and BYPASS is the reset
// instruction.
module jtag_ir_dr_path #(
    parameter int              IR_W       = 4,
    parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_W-1:0] OP_EXTEST  = IR_W'(4'b0000),
    parameter logic [IR_W-1:0] OP_SAMPLE  = IR_W'(4'b0001),
    parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(4'b0010)
) (
    input logic              TCK,
    input logic              TRST,
    jtag_ir_dr_path_if.slave bus
);

    // Capture-IR pattern: the mandatory "01" in the two LSBs.
    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-1){1'b0}}, 1'b1};
`ifdef IDCODE_EN
    localparam logic [IR_W-1:0] INSTR_RESET = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] INSTR_RESET = {IR_W{1'b1}};
`endif

    logic [IR_W-1:0] ir_sr;
    logic [IR_W-1:0] instr_q;
    logic            byp;
    logic            sel_bypass_c;
    logic            sel_idcode_c;
    logic            sel_bsr_c;
    logic            bsr_mode_c;
    logic            tdo_c;

    // IR shift register and instruction latch; capture beats shift beats update.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            ir_sr   <= IR_CAPTURE;
            instr_q <= INSTR_RESET;
        end else if (bus.clockir) begin
            ir_sr <= IR_CAPTURE;
        end else if (bus.shiftir) begin
            ir_sr <= {bus.TDI, ir_sr[IR_W-1:1]};
        end else if (bus.updateir) begin
            instr_q <= ir_sr;
        end
    end

    // Instruction decode: anything not explicitly recognised lands on BYPASS.
    always_comb begin
        sel_bypass_c = 1'b1;
        sel_idcode_c = 1'b0;
        sel_bsr_c    = 1'b0;
        bsr_mode_c   = 1'b0;
        if (instr_q == OP_EXTEST) begin
            sel_bypass_c = 1'b0;
            sel_bsr_c    = 1'b1;
            bsr_mode_c   = 1'b1;
        end else if (instr_q == OP_SAMPLE) begin
            sel_bypass_c = 1'b0;
            sel_bsr_c    = 1'b1;
        end
`ifdef IDCODE_EN
        else if (instr_q == OP_IDCODE) begin
            sel_bypass_c = 1'b0;
            sel_idcode_c = 1'b1;
        end
`endif
    end

    // BYPASS bit: only moves while BYPASS is the selected data register.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            byp <= 1'b0;
        end else if (sel_bypass_c) begin
            if (bus.clockdr) begin
                byp <= 1'b0;
            end else if (bus.shiftdr) begin
                byp <= bus.TDI;
            end
        end
    end

`ifdef IDCODE_EN
    logic [31:0] id_sr;

    // IDCODE register: reloads on capture, shifts LSB first while selected.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            id_sr <= IDCODE_VAL;
        end else if (sel_idcode_c) begin
            if (bus.clockdr) begin
                id_sr <= IDCODE_VAL;
            end else if (bus.shiftdr) begin
                id_sr <= {bus.TDI, id_sr[31:1]};
            end
        end
    end

    // TDO mux: IR when select is high, else the currently selected DR.
    always_comb begin
        tdo_c = byp;
        if (bus.select) begin
            tdo_c = ir_sr[0];
        end else if (sel_bsr_c) begin
            tdo_c = bus.bsr_tdo;
        end else if (sel_idcode_c) begin
            tdo_c = id_sr[0];
        end
    end
`else
    // IDCODE value and opcode have no consumer without the IDCODE register.
    logic unused_idcode_cfg;
    assign unused_idcode_cfg = ^{IDCODE_VAL, OP_IDCODE};

    // TDO mux: IR when select is high, else BSR or BYPASS.
    always_comb begin
        tdo_c = byp;
        if (bus.select) begin
            tdo_c = ir_sr[0];
        end else if (sel_bsr_c) begin
            tdo_c = bus.bsr_tdo;
        end
    end
`endif

    // Update-DR belongs to the external boundary-scan chain, not this block.
    logic unused_updatedr;
    assign unused_updatedr = bus.updatedr;

    assign bus.TDO        = tdo_c;
    assign bus.tdo_en     = bus.shiftir | bus.shiftdr;
    assign bus.instr      = instr_q;
    assign bus.sel_bypass = sel_bypass_c;
    assign bus.sel_idcode = sel_idcode_c;
    assign bus.sel_bsr    = sel_bsr_c;
    assign bus.bsr_mode   = bsr_mode_c;

endmodule

// File: tb/tb_jtag_ir_dr_path.sv
// Scoreboard bench for jtag_ir_dr_path. The driver applies one TCK cycle of
// strobes at a time, pushes the expected TDO / status into queues from a
// bit-queue reference model, and an independent monitor pops and compares.
module tb_jtag_ir_dr_path;
    localparam int              IR_W       = 4;
    localparam logic [31:0]     IDCODE_VAL = 32'h1000_0001;
    localparam logic [IR_W-1:0] OP_EXTEST  = 4'b0000;
    localparam logic [IR_W-1:0] OP_SAMPLE  = 4'b0001;
    localparam logic [IR_W-1:0] OP_IDCODE  = 4'b0010;
`ifdef IDCODE_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    localparam int K_BYP = 0;
    localparam int K_ID  = 1;
    localparam int K_BSR = 2;

    logic TCK;
    logic TRST;
    jtag_ir_dr_path_if #(.IR_W(IR_W)) bus ();

    jtag_ir_dr_path #(
        .IR_W(IR_W), .IDCODE_VAL(IDCODE_VAL),
        .OP_EXTEST(OP_EXTEST), .OP_SAMPLE(OP_SAMPLE), .OP_IDCODE(OP_IDCODE)
    ) dut (
        .TCK (TCK),
        .TRST(TRST),
        .bus (bus)
    );

    initial begin
        TCK = 1'b0;
        forever #5 TCK = ~TCK;
    end

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;
    bit stat_req = 1'b0;

    bit               tdo_q[$];
    logic [IR_W+3:0]  stat_q[$];

    // Reference model: serial registers as bit queues, front = bit seen on TDO.
    bit              ir_q[$];
    bit              id_q[$];
    bit              m_byp;
    logic [IR_W-1:0] m_instr;

    function automatic int kind_of(logic [IR_W-1:0] op);
        if (op == OP_EXTEST || op == OP_SAMPLE) return K_BSR;
        if (ID_EN && op == OP_IDCODE) return K_ID;
        return K_BYP;
    endfunction

    function automatic logic [IR_W+3:0] exp_status();
        int k;
        k = kind_of(m_instr);
        return {m_instr, k == K_BYP, k == K_ID, k == K_BSR, m_instr == OP_EXTEST};
    endfunction

    task automatic load_id_model();
        logic [31:0] v;
        v = IDCODE_VAL;
        id_q = {};
        for (int i = 0; i < 32; i++) id_q.push_back(v[i]);
    endtask

    task automatic capture_ir_model();
        ir_q = {};
        ir_q.push_back(1'b1);
        for (int i = 1; i < IR_W; i++) ir_q.push_back(1'b0);
    endtask

    task automatic model_reset();
        capture_ir_model();
        load_id_model();
        m_byp   = 1'b0;
        m_instr = ID_EN ? OP_IDCODE : {IR_W{1'b1}};
    endtask

    task automatic model_step(input bit trst, input bit cir, input bit sir,
                              input bit uir, input bit cdr, input bit sdr,
                              input bit tdi);
        int k;
        logic [IR_W-1:0] v;
        if (trst) begin
            model_reset();
            return;
        end
        k = kind_of(m_instr);
        if (cir) begin
            capture_ir_model();
        end else if (sir) begin
            void'(ir_q.pop_front());
            ir_q.push_back(tdi);
        end else if (uir) begin
            for (int i = 0; i < IR_W; i++) v[i] = ir_q[i];
            m_instr = v;
        end
        if (k == K_BYP) begin
            if (cdr) m_byp = 1'b0;
            else if (sdr) m_byp = tdi;
        end else if (k == K_ID) begin
            if (cdr) load_id_model();
            else if (sdr) begin
                void'(id_q.pop_front());
                id_q.push_back(tdi);
            end
        end
    endtask

    // One TCK cycle: drive at the falling edge, queue expectations, advance model.
    task automatic cyc(input bit trst, input bit cir, input bit sir, input bit uir,
                       input bit cdr, input bit sdr, input bit sel, input bit tdi,
                       input bit btdo, input bit stat);
        bit e;
        int k;
        @(negedge TCK);
        TRST         = trst;
        bus.clockir  = cir;
        bus.shiftir  = sir;
        bus.updateir = uir;
        bus.clockdr  = cdr;
        bus.shiftdr  = sdr;
        bus.updatedr = 1'b0;
        bus.select   = sel;
        bus.TDI      = tdi;
        bus.bsr_tdo  = btdo;
        stat_req     = stat;
        if (stat) stat_q.push_back(exp_status());
        if (sir || sdr) begin
            k = kind_of(m_instr);
            if (sel) e = ir_q[0];
            else if (k == K_BSR) e = btdo;
            else if (k == K_ID) e = id_q[0];
            else e = m_byp;
            tdo_q.push_back(e);
        end
        model_step(trst, cir, sir, uir, cdr, sdr, tdi);
    endtask

    task automatic idle_stat();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic load_ir(input logic [IR_W-1:0] op);
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < IR_W; i++) cyc(0, 0, 1, 0, 0, 0, 1, op[i], 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    endtask

    // Monitor: samples shortly before each rising edge, independent of the driver.
    initial begin
        bit e;
        logic [IR_W+3:0] s_exp;
        logic [IR_W+3:0] s_act;
        forever begin
            @(negedge TCK);
            #3;
            if (mon_en) begin
                checks++;
                if (!$onehot({bus.sel_bypass, bus.sel_idcode, bus.sel_bsr})) begin
                    failures++;
                    $display("FAIL sel_onehot act=%b req=one-hot",
                             {bus.sel_bypass, bus.sel_idcode, bus.sel_bsr});
                end
                if (bus.tdo_en === 1'b1) begin
                    checks++;
                    if (tdo_q.size() == 0) begin
                        failures++;
                        $display("FAIL tdo_en act=1 req=0 at %0t", $time);
                    end else begin
                        e = tdo_q.pop_front();
                        if (bus.TDO !== e) begin
                            failures++;
                            $display("FAIL tdo act=%b req=%b at %0t", bus.TDO, e, $time);
                        end
                    end
                end
                if (stat_req) begin
                    checks++;
                    s_act = {bus.instr, bus.sel_bypass, bus.sel_idcode, bus.sel_bsr, bus.bsr_mode};
                    if (stat_q.size() == 0) begin
                        failures++;
                        $display("FAIL status_queue empty at %0t", $time);
                    end else begin
                        s_exp = stat_q.pop_front();
                        if (s_act !== s_exp) begin
                            failures++;
                            $display("FAIL status act=%b req=%b (instr,byp,id,bsr,mode) at %0t",
                                     s_act, s_exp, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [IR_W-1:0] ops [6];
        TRST = 1'b1;
        bus.TDI = 0; bus.clockir = 0; bus.shiftir = 0; bus.updateir = 0;
        bus.clockdr = 0; bus.shiftdr = 0; bus.updatedr = 0;
        bus.select = 0; bus.bsr_tdo = 0;
        model_reset();

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        idle_stat();

        // Capture-DR then 32 shifts on the reset instruction.
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1'($urandom), 0, 0);

        // IR capture then shift of all ones, update to BYPASS.
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        idle_stat();

        // BYPASS one-cycle delay.
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);

        // EXTEST: TDO follows bsr_tdo.
        load_ir(OP_EXTEST);
        idle_stat();
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1'($urandom), 1'(i), 0);
        load_ir(OP_SAMPLE);
        idle_stat();

        // Undefined opcode, then BYPASS without capture shows the held bit.
        load_ir(4'b0110);
        idle_stat();
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1'($urandom), 0, 0);

        // Capture and shift together: capture wins.
        cyc(0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);

        // Reset in the middle of Shift-IR.
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        idle_stat();
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        load_ir(OP_IDCODE);
        idle_stat();
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1'($urandom), 0, 0);

        // Randomised mix of strobes and instruction loads.
        ops[0] = OP_EXTEST; ops[1] = OP_SAMPLE; ops[2] = OP_IDCODE;
        ops[3] = 4'b1111;   ops[4] = 4'b0110;  ops[5] = 4'b1010;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 13);
            if ($urandom_range(0, 63) == 0) begin
                cyc(1, 1'($urandom), 1'($urandom), 0, 0, 0, 1, 1'($urandom), 0, 0);
            end else begin
                case (r)
                    0:       cyc(0, 0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
                    1:       cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
                    2, 3, 4: cyc(0, 0, 1, 0, 0, 0, 1, 1'($urandom), 0, 0);
                    5:       cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
                    6:       cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
                    7, 8, 9: cyc(0, 0, 0, 0, 0, 1, 0, 1'($urandom), 1'($urandom), 0);
                    10:      idle_stat();
                    11:      cyc(0, 1, 1, 0, 0, 0, 1, 1'($urandom), 0, 0);
                    12:      cyc(0, 0, 0, 0, 1, 1, 0, 1'($urandom), 1'($urandom), 0);
                    default: begin
                        load_ir(ops[$urandom_range(0, 5)]);
                        idle_stat();
                    end
                endcase
            end
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge TCK);
        #5;
        checks++;
        if (tdo_q.size() != 0) begin
            failures++;
            $display("FAIL tdo_leftover act=%0d req=0", tdo_q.size());
        end
        checks++;
        if (stat_q.size() != 0) begin
            failures++;
            $display("FAIL status_leftover act=%0d req=0", stat_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtag_ir_dr_path.md
Name: jtag_ir_dr_path

Overview:
- Data-path stage directly downstream of tapcontroller, in the TCK domain.
- Consumes tapcontroller's capture, shift, update and select strobes.
- Implements the instruction register and decoder, the 1-bit BYPASS register and the 32-bit IDCODE register.
- Drives the TDO mux and the boundary-scan control outputs to the external BSR chain.

Parameters:
- IR_W, 4, instruction register width (>=2).
- IDCODE_VAL, 32'h1000_0001, value loaded into IDCODE in Capture-DR; bit0 must be 1.
- OP_EXTEST, 4'b0000, EXTEST opcode.
- OP_SAMPLE, 4'b0001, SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0010, IDCODE opcode.

Ports:
- TCK  in  1  test clock; all state updates on rising edge.
- TRST  in  1  synchronous, active-high reset (sampled on TCK rising edge).
- TDI  in  1  serial test data in.
- clockir  in  1  high during Capture-IR.
- shiftir  in  1  high during Shift-IR.
- updateir  in  1  high during Update-IR.
- clockdr  in  1  high during Capture-DR.
- shiftdr  in  1  high during Shift-DR.
- updatedr  in  1  high during Update-DR; not consumed internally, forwarded via the BSR.
- select  in  1  1 = IR path selected for TDO, 0 = DR path.
- bsr_tdo  in  1  serial out of the external boundary-scan chain.
- TDO  out  1  serial test data out.
- tdo_en  out  1  TDO output enable.
- instr  out  IR_W  active instruction.
- sel_bypass  out  1  BYPASS register selected.
- sel_idcode  out  1  IDCODE register selected.
- sel_bsr  out  1  BSR selected (EXTEST or SAMPLE).
- bsr_mode  out  1  high only for EXTEST; drives BSR output muxes.

Behaviour:
- Registers: ir_sr[IR_W-1:0] (shift), instr[IR_W-1:0] (update latch), byp (1 bit), id_sr[31:0].
- Reset (TRST=1 at a rising edge):
  - ir_sr = {0..0,01}, byp = 0, id_sr = IDCODE_VAL.
  - instr = OP_IDCODE if IDCODE_EN is defined, else all-ones (BYPASS).
  - Reset wins over every strobe in the same cycle.
  - Reset mid-shift discards partial contents; instr takes its reset value.
- IR path, priority clockir > shiftir > updateir (controller keeps them exclusive; this priority is mandatory):
  - clockir: ir_sr <= {0..0,01}.
  - shiftir: ir_sr <= {TDI, ir_sr[IR_W-1:1]} (LSB first out).
  - updateir: instr <= ir_sr, effective the next cycle.
  - instr changes only on updateir or reset.
- Decode (combinational from instr):
  - OP_EXTEST -> sel_bsr=1, bsr_mode=1.
  - OP_SAMPLE -> sel_bsr=1, bsr_mode=0.
  - OP_IDCODE -> sel_idcode=1 when IDCODE_EN is defined, else sel_bypass=1.
  - All-ones and every undefined opcode -> sel_bypass=1.
  - Exactly one of sel_bypass, sel_idcode, sel_bsr is high at all times.
- DR path, acting only on the register selected by the current instr:
  - clockdr: byp <= 0; id_sr <= IDCODE_VAL.
  - shiftdr: byp <= TDI; id_sr <= {TDI, id_sr[31:1]}.
  - clockdr has priority over shiftdr.
  - Unselected DR registers hold.
- TDO (combinational, zero latency from register state):
  - select=1 -> ir_sr[0].
  - select=0 -> byp, id_sr[0] or bsr_tdo, per the active selection.
- tdo_en = shiftir | shiftdr; TDO value is don't-care when tdo_en=0.
- Latency: BYPASS path TDI->TDO is exactly 1 TCK. IDCODE shift yields IDCODE_VAL bits LSB first, one per cycle, starting with the first shiftdr cycle.

Optional Feature:
- Macro IDCODE_EN.
- Defined: id_sr is instantiated; OP_IDCODE selects it; reset instr = OP_IDCODE.
- Undefined: id_sr is omitted; OP_IDCODE decodes as BYPASS; reset instr = all-ones; sel_idcode is tied 0.

Test Plan:
- Reset, IDCODE_EN defined: TRST=1 for 2 TCK -> instr=4'b0010, sel_idcode=1. Then clockdr for 1 cycle and shiftdr for 32 cycles -> TDO emits 32'h1000_0001 LSB first, first bit 1.
- IR capture/shift: clockir, then shiftir for 4 cycles with TDI=1,1,1,1 -> TDO=1,0,0,0. Then updateir -> instr=4'b1111, sel_bypass=1.
- BYPASS: clockdr, then shiftdr with TDI=1,0,1,1 -> TDO=0,1,0,1 (one-cycle delay, captured 0 first).
- EXTEST load: shift in 4'b0000, then updateir -> sel_bsr=1, bsr_mode=1. With select=0, shiftdr and bsr_tdo toggling -> TDO follows bsr_tdo; byp and id_sr unchanged.
- Undefined opcode 4'b0110 loaded -> sel_bypass=1. Separately, assert clockir and shiftir together -> ir_sr=0001 (capture wins).
- Reset mid-shift: during Shift-IR after 2 bits, pulse TRST -> ir_sr=0001 and instr=reset value next cycle. Build without IDCODE_EN -> reset instr=4'b1111; loading 4'b0010 gives sel_bypass=1.
